// File: rtl/vga_fill.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | vga_fill : clipped rectangle fill engine, one framebuffer write per clock |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
module vga_fill #(
  parameter int HSIZE = 320,
  parameter int VSIZE = 240,
  parameter int HW    = 9,
  parameter int VW    = 8
) (
  input  logic          rclk,
  input  logic          rst,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [HW-1:0] cmd_x,
  input  logic [VW-1:0] cmd_y,
  input  logic [HW-1:0] cmd_w,
  input  logic [VW-1:0] cmd_h,
  input  logic [11:0]   cmd_color,
  input  logic          abort,
  output logic          busy,
  output logic          done,
  output logic          we,
  output logic [HW-1:0] haddr,
  output logic [VW-1:0] vaddr,
  output logic [11:0]   wdata
);

  localparam logic [1:0] c_IDLE = 2'd0;
  localparam logic [1:0] c_FILL = 2'd1;
  localparam logic [1:0] c_DONE = 2'd2;

  localparam logic [HW:0]   c_HSIZE = (HW+1)'(HSIZE);
  localparam logic [VW:0]   c_VSIZE = (VW+1)'(VSIZE);
  localparam logic [HW-1:0] c_HLAST = HW'(HSIZE - 1);
  localparam logic [VW-1:0] c_VLAST = VW'(VSIZE - 1);
  localparam logic [HW-1:0] c_HONE  = HW'(1);
  localparam logic [VW-1:0] c_VONE  = VW'(1);

  logic [1:0]    r_state;
  logic [HW-1:0] r_x0;
  logic [HW-1:0] r_xlast;
  logic [VW-1:0] r_ylast;
  logic [HW-1:0] r_cx;
  logic [VW-1:0] r_cy;
  logic [11:0]   r_color;
  logic          r_we;
  logic          r_done;
  logic          r_busy;

  logic [HW:0]   w_xsum;
  logic [VW:0]   w_ysum;
  logic          w_zero;
  logic [HW-1:0] w_xlast;
  logic [VW-1:0] w_ylast;
  logic          w_row_end;
  logic          w_last_pix;

  // Sums carry one extra bit so origin+size can never wrap before clipping.
  assign w_xsum = {1'b0, cmd_x} + {1'b0, cmd_w};
  assign w_ysum = {1'b0, cmd_y} + {1'b0, cmd_h};

  assign w_zero = (cmd_w == '0) || (cmd_h == '0) ||
                  ({1'b0, cmd_x} >= c_HSIZE) || ({1'b0, cmd_y} >= c_VSIZE);

  // Inclusive last coordinate; only meaningful when the area is non-zero.
  assign w_xlast = (w_xsum > c_HSIZE) ? c_HLAST : (cmd_x + cmd_w - c_HONE);
  assign w_ylast = (w_ysum > c_VSIZE) ? c_VLAST : (cmd_y + cmd_h - c_VONE);

  assign w_row_end  = (r_cx == r_xlast);
  assign w_last_pix = w_row_end && (r_cy == r_ylast);

  always_ff @(posedge rclk or negedge rst) begin
    if (!rst) begin
      r_state <= c_IDLE;
      r_x0    <= '0;
      r_xlast <= '0;
      r_ylast <= '0;
      r_cx    <= '0;
      r_cy    <= '0;
      r_color <= '0;
      r_we    <= 1'b0;
      r_done  <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      case (r_state)
        c_IDLE: begin
          if (cmd_valid) begin
            r_x0    <= cmd_x;
            r_xlast <= w_xlast;
            r_ylast <= w_ylast;
            r_cx    <= cmd_x;
            r_cy    <= cmd_y;
            r_color <= cmd_color;
            r_busy  <= 1'b1;
            if (w_zero) begin
              r_state <= c_DONE;
              r_done  <= 1'b1;
            end else begin
              r_state <= c_FILL;
              r_we    <= 1'b1;
            end
          end
        end
        c_FILL: begin
          // The pixel on the outputs now is always written; abort only stops the next.
          if (abort || w_last_pix) begin
            r_state <= c_DONE;
            r_we    <= 1'b0;
            r_done  <= 1'b1;
          end else if (w_row_end) begin
            r_cx <= r_x0;
            r_cy <= r_cy + c_VONE;
          end else begin
            r_cx <= r_cx + c_HONE;
          end
        end
        c_DONE: begin
          r_state <= c_IDLE;
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state <= c_IDLE;
          r_we    <= 1'b0;
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign cmd_ready = (r_state == c_IDLE);
  assign busy      = r_busy;
  assign done      = r_done;
  assign we        = r_we;
  assign haddr     = r_cx;
  assign vaddr     = r_cy;
  assign wdata     = r_color;

endmodule
`default_nettype wire

// File: tb/tb_vga_fill.sv
`default_nettype none
// Bench for vga_fill: per-scenario tasks with a pixel scoreboard queue.
module tb_vga_fill;
  localparam int HW = 9;
  localparam int VW = 8;

  logic          rclk = 1'b0;
  logic          rst = 1'b0;
  logic          cmd_valid = 1'b0;
  logic          abort = 1'b0;
  logic [HW-1:0] cmd_x = '0;
  logic [VW-1:0] cmd_y = '0;
  logic [HW-1:0] cmd_w = '0;
  logic [VW-1:0] cmd_h = '0;
  logic [11:0]   cmd_color = '0;
  logic          cmd_ready, busy, done, we;
  logic [HW-1:0] haddr;
  logic [VW-1:0] vaddr;
  logic [11:0]   wdata;

  vga_fill #(.HSIZE(320), .VSIZE(240), .HW(HW), .VW(VW)) dut (
    .rclk(rclk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_x(cmd_x), .cmd_y(cmd_y), .cmd_w(cmd_w), .cmd_h(cmd_h),
    .cmd_color(cmd_color), .abort(abort), .busy(busy), .done(done),
    .we(we), .haddr(haddr), .vaddr(vaddr), .wdata(wdata)
  );

  always #5 rclk = ~rclk;

  int n_cmp = 0;
  int n_err = 0;
  logic [28:0] exp_q[$];
  logic [28:0] obs_q[$];
  int n_we, t_first, t_last, t_done, n_done, t_ready, n_busy;

  // Drives one command and pushes the model's expected pixel stream (at most limit pixels).
  task automatic send_cmd(input int x, input int y, input int w, input int h,
                          input logic [11:0] col, input int limit, input logic ab);
    int k, xe, ye, cnt;
    k = 0;
    while (cmd_ready !== 1'b1 && k < 200) begin
      @(negedge rclk);
      k++;
    end
    n_cmp++;
    if (cmd_ready !== 1'b1) begin
      n_err++;
      $display("FAIL ready_wait: cmd_ready=%b required 1", cmd_ready);
    end
    xe = (x + w > 320) ? 320 : x + w;
    ye = (y + h > 240) ? 240 : y + h;
    cnt = 0;
    if (w != 0 && h != 0 && x < 320 && y < 240)
      for (int yy = y; yy < ye; yy++)
        for (int xx = x; xx < xe; xx++)
          if (cnt < limit) begin
            exp_q.push_back({HW'(xx), VW'(yy), col});
            cnt++;
          end
    cmd_x = HW'(x); cmd_y = VW'(y); cmd_w = HW'(w); cmd_h = VW'(h);
    cmd_color = col; abort = ab; cmd_valid = 1'b1;
    @(posedge rclk);
    #1;
    cmd_valid = 1'b0; abort = 1'b0;
    cmd_x = HW'($urandom); cmd_y = VW'($urandom); cmd_w = HW'($urandom);
    cmd_h = VW'($urandom); cmd_color = 12'($urandom);
  endtask

  // Observes cycles after acceptance (cycle 1 = first cycle after the accept edge).
  task automatic collect(input int budget, input int abort_at);
    n_we = 0; t_first = 0; t_last = 0; t_done = 0; n_done = 0; t_ready = 0; n_busy = 0;
    for (int c = 1; c <= budget; c++) begin
      @(negedge rclk);
      if (we) begin
        n_we++;
        if (t_first == 0) t_first = c;
        t_last = c;
        obs_q.push_back({haddr, vaddr, wdata});
      end
      if (done) begin
        n_done++;
        if (t_done == 0) t_done = c;
      end
      if (busy) n_busy++;
      if (cmd_ready) begin
        t_ready = c;
        break;
      end
      if (c == abort_at) abort = 1'b1;
    end
    abort = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge rclk);
    n_cmp++; if (we !== 1'b0) begin n_err++; $display("FAIL reset_we: got %b required 0", we); end
    n_cmp++; if (haddr !== '0) begin n_err++; $display("FAIL reset_haddr: got %0d required 0", haddr); end
    n_cmp++; if (vaddr !== '0) begin n_err++; $display("FAIL reset_vaddr: got %0d required 0", vaddr); end
    n_cmp++; if (wdata !== '0) begin n_err++; $display("FAIL reset_wdata: got %h required 0", wdata); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b required 0", busy); end
    n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL reset_done: got %b required 0", done); end
    n_cmp++; if (cmd_ready !== 1'b1) begin n_err++; $display("FAIL reset_ready: got %b required 1", cmd_ready); end
  endtask

  task automatic test_full_screen();
    int n;
    logic [28:0] e, o;
    send_cmd(0, 0, 320, 240, 12'hF00, 1 << 30, 1'b0);
    collect(76810, 0);
    n_cmp++; if (n_we != 76800) begin n_err++; $display("FAIL full_count: got %0d required 76800", n_we); end
    n_cmp++; if (t_first != 1 || t_last != 76800) begin n_err++; $display("FAIL full_span: got %0d..%0d required 1..76800", t_first, t_last); end
    n_cmp++; if (t_done != 76801 || n_done != 1) begin n_err++; $display("FAIL full_done: got cyc %0d x%0d required cyc 76801 x1", t_done, n_done); end
    n_cmp++; if (t_ready != 76802) begin n_err++; $display("FAIL full_ready: got %0d required 76802", t_ready); end
    n = exp_q.size();
    for (int i = 0; i < n; i++) begin
      e = exp_q.pop_front();
      if (obs_q.size() > 0) o = obs_q.pop_front(); else o = 'x;
      n_cmp++;
      if (o !== e) begin n_err++; $display("FAIL full_pixel %0d: got %h required %h", i, o, e); end
    end
    obs_q.delete();
  endtask

  task automatic test_small();
    int n;
    logic [28:0] e, o;
    send_cmd(10, 5, 3, 2, 12'h0A5, 1 << 30, 1'b0);
    collect(30, 0);
    n_cmp++; if (n_we != 6 || t_first != 1 || t_last != 6) begin n_err++; $display("FAIL small_we: got %0d in %0d..%0d required 6 in 1..6", n_we, t_first, t_last); end
    n_cmp++; if (t_done != 7) begin n_err++; $display("FAIL small_done: got %0d required 7", t_done); end
    n_cmp++; if (t_ready != 8) begin n_err++; $display("FAIL small_ready: got %0d required 8", t_ready); end
    n_cmp++; if (n_busy != 7) begin n_err++; $display("FAIL small_busy: got %0d required 7", n_busy); end
    n = exp_q.size();
    for (int i = 0; i < n; i++) begin
      e = exp_q.pop_front();
      if (obs_q.size() > 0) o = obs_q.pop_front(); else o = 'x;
      n_cmp++;
      if (o !== e) begin n_err++; $display("FAIL small_pixel %0d: got %h required %h", i, o, e); end
    end
    obs_q.delete();
  endtask

  task automatic test_clip();
    int n;
    logic [28:0] e, o;
    send_cmd(318, 239, 5, 4, 12'h3C7, 1 << 30, 1'b0);
    collect(30, 0);
    n_cmp++; if (n_we != 2) begin n_err++; $display("FAIL clip_count: got %0d required 2", n_we); end
    n_cmp++; if (t_done != 3 || t_ready != 4) begin n_err++; $display("FAIL clip_timing: got done %0d ready %0d required 3 4", t_done, t_ready); end
    n = exp_q.size();
    for (int i = 0; i < n; i++) begin
      e = exp_q.pop_front();
      if (obs_q.size() > 0) o = obs_q.pop_front(); else o = 'x;
      n_cmp++;
      if (o !== e) begin n_err++; $display("FAIL clip_pixel %0d: got %h required %h", i, o, e); end
    end
    obs_q.delete();
    send_cmd(320, 10, 10, 5, 12'hFFF, 1 << 30, 1'b0);
    collect(30, 0);
    n_cmp++; if (n_we != 0) begin n_err++; $display("FAIL clip_offscreen_we: got %0d required 0", n_we); end
    n_cmp++; if (t_done != 1 || t_ready != 2) begin n_err++; $display("FAIL clip_offscreen_timing: got done %0d ready %0d required 1 2", t_done, t_ready); end
    obs_q.delete();
  endtask

  task automatic test_zero();
    send_cmd(40, 40, 0, 5, 12'h123, 1 << 30, 1'b0);
    collect(30, 0);
    n_cmp++; if (n_we != 0) begin n_err++; $display("FAIL zero_w_we: got %0d required 0", n_we); end
    n_cmp++; if (t_done != 1 || t_ready != 2 || n_busy != 1) begin n_err++; $display("FAIL zero_w_timing: got done %0d ready %0d busy %0d required 1 2 1", t_done, t_ready, n_busy); end
    send_cmd(40, 40, 5, 0, 12'h456, 1 << 30, 1'b0);
    collect(30, 0);
    n_cmp++; if (n_we != 0) begin n_err++; $display("FAIL zero_h_we: got %0d required 0", n_we); end
    n_cmp++; if (t_done != 1 || t_ready != 2) begin n_err++; $display("FAIL zero_h_timing: got done %0d ready %0d required 1 2", t_done, t_ready); end
    obs_q.delete();
  endtask

  task automatic test_abort();
    int n;
    logic [28:0] e, o;
    send_cmd(30, 40, 20, 20, 12'h5AF, 7, 1'b0);
    collect(600, 7);
    n_cmp++; if (n_we != 7) begin n_err++; $display("FAIL abort_count: got %0d required 7", n_we); end
    n_cmp++; if (t_done != 8 || n_done != 1 || t_ready != 9) begin n_err++; $display("FAIL abort_timing: got done %0d x%0d ready %0d required 8 x1 9", t_done, n_done, t_ready); end
    n = exp_q.size();
    for (int i = 0; i < n; i++) begin
      e = exp_q.pop_front();
      if (obs_q.size() > 0) o = obs_q.pop_front(); else o = 'x;
      n_cmp++;
      if (o !== e) begin n_err++; $display("FAIL abort_pixel %0d: got %h required %h", i, o, e); end
    end
    obs_q.delete();
    send_cmd(200, 100, 4, 3, 12'h0F0, 1 << 30, 1'b1);
    collect(50, 0);
    n_cmp++; if (n_we != 12 || t_done != 13) begin n_err++; $display("FAIL abort_idle: got %0d writes done %0d required 12 13", n_we, t_done); end
    n = exp_q.size();
    for (int i = 0; i < n; i++) begin
      e = exp_q.pop_front();
      if (obs_q.size() > 0) o = obs_q.pop_front(); else o = 'x;
      n_cmp++;
      if (o !== e) begin n_err++; $display("FAIL abort_idle_pixel %0d: got %h required %h", i, o, e); end
    end
    obs_q.delete();
  endtask

  task automatic test_back_to_back();
    int n;
    logic [28:0] e, o;
    send_cmd(5, 5, 2, 2, 12'hABC, 1 << 30, 1'b0);
    collect(30, 0);
    n_cmp++; if (t_ready != 6) begin n_err++; $display("FAIL b2b_spacing: got %0d required 6", t_ready); end
    send_cmd(100, 200, 4, 1, 12'hDEF, 1 << 30, 1'b0);
    collect(30, 0);
    n_cmp++; if (n_we != 4 || t_first != 1 || t_done != 5) begin n_err++; $display("FAIL b2b_second: got %0d writes first %0d done %0d required 4 1 5", n_we, t_first, t_done); end
    n = exp_q.size();
    for (int i = 0; i < n; i++) begin
      e = exp_q.pop_front();
      if (obs_q.size() > 0) o = obs_q.pop_front(); else o = 'x;
      n_cmp++;
      if (o !== e) begin n_err++; $display("FAIL b2b_pixel %0d: got %h required %h", i, o, e); end
    end
    obs_q.delete();
  endtask

  task automatic test_async_reset();
    int n;
    logic [28:0] e, o;
    send_cmd(50, 60, 100, 100, 12'h777, 50, 1'b0);
    collect(50, 0);
    n_cmp++; if (n_we != 50) begin n_err++; $display("FAIL arst_prewrites: got %0d required 50", n_we); end
    #2 rst = 1'b0;
    #1;
    n_cmp++; if (we !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin n_err++; $display("FAIL arst_drop: got we %b busy %b done %b required 0 0 0", we, busy, done); end
    n_cmp++; if (cmd_ready !== 1'b1 || haddr !== '0) begin n_err++; $display("FAIL arst_state: got ready %b haddr %0d required 1 0", cmd_ready, haddr); end
    n = exp_q.size();
    for (int i = 0; i < n; i++) begin
      e = exp_q.pop_front();
      if (obs_q.size() > 0) o = obs_q.pop_front(); else o = 'x;
      n_cmp++;
      if (o !== e) begin n_err++; $display("FAIL arst_pixel %0d: got %h required %h", i, o, e); end
    end
    obs_q.delete();
    repeat (2) @(negedge rclk);
    rst = 1'b1;
    @(negedge rclk);
    n_cmp++; if (cmd_ready !== 1'b1 || done !== 1'b0) begin n_err++; $display("FAIL arst_release: got ready %b done %b required 1 0", cmd_ready, done); end
    send_cmd(1, 2, 3, 3, 12'h9E1, 1 << 30, 1'b0);
    collect(30, 0);
    n_cmp++; if (n_we != 9 || t_done != 10 || t_ready != 11) begin n_err++; $display("FAIL arst_rerun: got %0d writes done %0d ready %0d required 9 10 11", n_we, t_done, t_ready); end
    n = exp_q.size();
    for (int i = 0; i < n; i++) begin
      e = exp_q.pop_front();
      if (obs_q.size() > 0) o = obs_q.pop_front(); else o = 'x;
      n_cmp++;
      if (o !== e) begin n_err++; $display("FAIL arst_rerun_pixel %0d: got %h required %h", i, o, e); end
    end
    obs_q.delete();
  endtask

  initial begin
    rst = 1'b0;
    repeat (2) @(negedge rclk);
    test_reset();
    rst = 1'b1;
    @(negedge rclk);
    test_full_screen();
    test_small();
    test_clip();
    test_zero();
    test_abort();
    test_back_to_back();
    test_async_reset();
    repeat (3) @(negedge rclk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
